// File: rtl/stairs_animator.sv
// stairs_animator: draws NUM_STAIRS filled rectangles one pixel per clock,
// holds them for a number of frames, erases them to the background colour,
// shifts every stair one pixel up or down (wrapping vertically) and repeats.
// Pixel outputs are registered: the pixel for the next scan position is
// computed combinationally and loaded on the edge that enters that position.
module stairs_animator #(
    parameter int         NUM_STAIRS      = 4,
    parameter int         STAIR_W         = 40,
    parameter int         STAIR_H         = 10,
    parameter int         X_PITCH         = 40,
    parameter int         Y_PITCH         = 10,
    parameter int         SCREEN_W        = 160,
    parameter int         SCREEN_H        = 120,
    parameter int         FRAME_DELAY     = 833333,
    parameter int         FRAMES_PER_STEP = 15,
    parameter logic [2:0] BG_COLOUR       = 3'b111
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       go,
    input  logic       stop,
    input  logic       dir,
    input  logic [2:0] colour,
    input  logic [7:0] base_x,
    input  logic [6:0] base_y,
    output logic [7:0] out_x,
    output logic [6:0] out_y,
    output logic [2:0] out_colour,
    output logic       plot,
    output logic       busy,
    output logic       step_done
);

    // Stair storage is sized for the maximum count so a 3-bit stair index
    // always addresses a real element; unused entries stay at zero.
    localparam int MAX_STAIRS = 8;
    localparam int DW = (FRAME_DELAY > 1) ? $clog2(FRAME_DELAY) : 1;
    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [2:0]    LAST_S     = 3'(NUM_STAIRS - 1);
    localparam logic [3:0]    LAST_R     = 4'(STAIR_H - 1);
    localparam logic [5:0]    LAST_C     = 6'(STAIR_W - 1);
    localparam logic [6:0]    Y_MAX      = 7'(SCREEN_H - 1);
    localparam logic [7:0]    Y_LIM      = 8'(SCREEN_H);
    localparam logic [8:0]    X_LIM      = 9'(SCREEN_W);
    localparam logic [DW-1:0] DELAY_LAST = DW'(FRAME_DELAY - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAW,
        S_HOLD,
        S_ERASE,
        S_MOVE
    } state_t;

    state_t        state_reg;
    logic [2:0]    colour_reg;
    logic [6:0]    y_reg [MAX_STAIRS];
    logic [8:0]    x_reg [MAX_STAIRS];
    logic [2:0]    s_reg;
    logic [3:0]    r_reg;
    logic [5:0]    c_reg;
    logic [DW-1:0] delay_reg;
    logic [FW-1:0] frame_reg;
    logic          stop_pending_reg;

    logic [6:0]    load_y [MAX_STAIRS];
    logic [8:0]    load_x [MAX_STAIRS];
    logic [6:0]    move_y [MAX_STAIRS];

    // Per-stair start positions (from the live base inputs) and wrapped moves.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_STAIRS; gi++) begin : g_stair
            if (gi < NUM_STAIRS) begin : g_used
                assign load_y[gi] = 7'((32'(base_y) + 32'(gi * Y_PITCH)) % 32'(SCREEN_H));
                assign load_x[gi] = {1'b0, base_x} + 9'(gi * X_PITCH);
                assign move_y[gi] = dir ? ((y_reg[gi] == Y_MAX) ? 7'd0 : y_reg[gi] + 7'd1)
                                        : ((y_reg[gi] == 7'd0) ? Y_MAX : y_reg[gi] - 7'd1);
            end else begin : g_unused
                assign load_y[gi] = '0;
                assign load_x[gi] = '0;
                assign move_y[gi] = '0;
            end
        end
    endgenerate

    logic       scan_last;
    logic       hold_done;
    logic       emit_pix;
    logic [2:0] nxt_s;
    logic [3:0] nxt_r;
    logic [5:0] nxt_c;
    logic [2:0] tgt_s;
    logic [3:0] tgt_r;
    logic [5:0] tgt_c;
    logic [6:0] sel_y;
    logic [8:0] sel_x;
    logic [7:0] sum_y;
    logic [8:0] pix_x;
    logic [6:0] pix_y;
    logic       pix_vis;
    logic [2:0] pix_colour;

    // Next scan position and the pixel that the coming edge should present.
    always_comb begin
        nxt_s = s_reg;
        nxt_r = r_reg;
        nxt_c = c_reg + 6'd1;
        if (c_reg == LAST_C) begin
            nxt_c = '0;
            if (r_reg == LAST_R) begin
                nxt_r = '0;
                nxt_s = s_reg + 3'd1;
            end else begin
                nxt_r = r_reg + 4'd1;
            end
        end
        scan_last = (s_reg == LAST_S) && (r_reg == LAST_R) && (c_reg == LAST_C);
        hold_done = (delay_reg == DELAY_LAST) && (frame_reg == FRAME_LAST);

        // A scan starts at position 0 when entering DRAW/ERASE, otherwise advances.
        if (state_reg == S_DRAW || state_reg == S_ERASE) begin
            tgt_s = nxt_s;
            tgt_r = nxt_r;
            tgt_c = nxt_c;
        end else begin
            tgt_s = '0;
            tgt_r = '0;
            tgt_c = '0;
        end

        case (state_reg)
            S_LOAD:        emit_pix = 1'b1;
            S_MOVE:        emit_pix = 1'b1;
            S_HOLD:        emit_pix = hold_done;
            S_DRAW,
            S_ERASE:       emit_pix = !scan_last;
            default:       emit_pix = 1'b0;
        endcase

        // Stair positions are not yet in registers in LOAD, and are being
        // updated in MOVE, so take them from the combinational sources there.
        sel_y = y_reg[tgt_s];
        sel_x = x_reg[tgt_s];
        if (state_reg == S_LOAD) begin
            sel_y = load_y[tgt_s];
            sel_x = load_x[tgt_s];
        end else if (state_reg == S_MOVE) begin
            sel_y = move_y[tgt_s];
        end

        sum_y = {1'b0, sel_y} + {4'd0, tgt_r};
        if (sum_y >= Y_LIM) begin
            sum_y = sum_y - Y_LIM;
        end
        pix_y   = sum_y[6:0];
        pix_x   = sel_x + {3'd0, tgt_c};
        pix_vis = (pix_x < X_LIM);

        case (state_reg)
            S_LOAD:         pix_colour = colour;
            S_DRAW, S_MOVE: pix_colour = colour_reg;
            default:        pix_colour = BG_COLOUR;
        endcase
    end

    // Main sequencer: state, stair positions, counters and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= S_IDLE;
            colour_reg       <= '0;
            s_reg            <= '0;
            r_reg            <= '0;
            c_reg            <= '0;
            delay_reg        <= '0;
            frame_reg        <= '0;
            stop_pending_reg <= 1'b0;
            out_x            <= '0;
            out_y            <= '0;
            out_colour       <= '0;
            plot             <= 1'b0;
            busy             <= 1'b0;
            step_done        <= 1'b0;
            for (int i = 0; i < MAX_STAIRS; i++) begin
                y_reg[i] <= '0;
                x_reg[i] <= '0;
            end
        end else begin
            plot      <= 1'b0;
            step_done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    stop_pending_reg <= 1'b0;
                    if (go && !stop) begin
                        state_reg <= S_LOAD;
                        busy      <= 1'b1;
                    end else begin
                        busy      <= 1'b0;
                    end
                end
                S_LOAD: begin
                    colour_reg <= colour;
                    for (int i = 0; i < MAX_STAIRS; i++) begin
                        y_reg[i] <= load_y[i];
                        x_reg[i] <= load_x[i];
                    end
                    state_reg <= S_DRAW;
                end
                S_DRAW: begin
                    if (scan_last) begin
                        state_reg <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (stop) begin
                        stop_pending_reg <= 1'b1;
                    end
                    if (delay_reg == DELAY_LAST) begin
                        delay_reg <= '0;
                        if (frame_reg == FRAME_LAST) begin
                            frame_reg <= '0;
                            state_reg <= S_ERASE;
                        end else begin
                            frame_reg <= frame_reg + FW'(1);
                        end
                    end else begin
                        delay_reg <= delay_reg + DW'(1);
                    end
                end
                S_ERASE: begin
                    if (scan_last) begin
                        if (stop_pending_reg) begin
                            state_reg <= S_IDLE;
                            busy      <= 1'b0;
                        end else begin
                            state_reg <= S_MOVE;
                            step_done <= 1'b1;
                        end
                    end
                end
                S_MOVE: begin
                    for (int i = 0; i < MAX_STAIRS; i++) begin
                        y_reg[i] <= move_y[i];
                    end
                    state_reg <= S_DRAW;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
            endcase

            if (emit_pix) begin
                s_reg      <= tgt_s;
                r_reg      <= tgt_r;
                c_reg      <= tgt_c;
                out_x      <= pix_x[7:0];
                out_y      <= pix_y;
                out_colour <= pix_colour;
                plot       <= pix_vis;
            end
        end
    end

endmodule

// File: tb/tb_stairs_animator.sv
// Testbench for stairs_animator: a reference model predicts every plotted
// pixel and step pulse (with its cycle) into a queue; a monitor pops and
// compares whenever the DUT asserts plot or step_done.
`timescale 1ns/1ps
module tb_stairs_animator;

    localparam int NS       = 2;
    localparam int W        = 4;
    localparam int H        = 2;
    localparam int XP       = 8;
    localparam int YP       = 10;
    localparam int SW       = 160;
    localparam int SH       = 120;
    localparam int FD       = 3;
    localparam int FPS      = 2;
    localparam int BG       = 7;
    localparam int SCAN     = NS * W * H;
    localparam int HOLD_CYC = FD * FPS;
    localparam int PERIOD   = 2 * SCAN + HOLD_CYC + 1;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       go      = 1'b0;
    logic       stop    = 1'b0;
    logic       dir     = 1'b0;
    logic [2:0] colour  = '0;
    logic [7:0] base_x  = '0;
    logic [6:0] base_y  = '0;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_colour;
    logic       plot;
    logic       busy;
    logic       step_done;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;   // 0 = pixel, 1 = step_done pulse
        int cyc;
        int x;
        int y;
        int col;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    bit  mon_ok;

    stairs_animator #(
        .NUM_STAIRS(NS), .STAIR_W(W), .STAIR_H(H), .X_PITCH(XP), .Y_PITCH(YP),
        .SCREEN_W(SW), .SCREEN_H(SH), .FRAME_DELAY(FD), .FRAMES_PER_STEP(FPS),
        .BG_COLOUR(3'b111)
    ) dut (
        .clock(clock), .reset_n(reset_n), .go(go), .stop(stop), .dir(dir),
        .colour(colour), .base_x(base_x), .base_y(base_y),
        .out_x(out_x), .out_y(out_y), .out_colour(out_colour),
        .plot(plot), .busy(busy), .step_done(step_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every DUT output event must match the head of the queue.
    always @(negedge clock) begin
        if (plot || step_done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: cyc=%0d plot=%0b step_done=%0b x=%0d y=%0d col=%0d, required no event",
                         cyc, plot, step_done, out_x, out_y, out_colour);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.kind == 1)
                    mon_ok = step_done && !plot && (cyc == mon_e.cyc);
                else
                    mon_ok = plot && !step_done && (cyc == mon_e.cyc) &&
                             (int'(out_x) == mon_e.x) && (int'(out_y) == mon_e.y) &&
                             (int'(out_colour) == mon_e.col);
                if (!mon_ok) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d plot=%0b step=%0b x=%0d y=%0d col=%0d, required cyc=%0d kind=%0d x=%0d y=%0d col=%0d",
                             cyc, plot, step_done, out_x, out_y, out_colour,
                             mon_e.cyc, mon_e.kind, mon_e.x, mon_e.y, mon_e.col);
                end
            end
        end
    end

    function automatic int wrap_y(input int v);
        return ((v % SH) + SH) % SH;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Model of one full scan of a step: stair outer, row, column inner.
    task automatic push_scan(input int t, input int bx, input int by, input int col,
                             input int step, input int d, input int limit);
        int p, x, y, dy;
        ev_t e;
        dy = (d != 0) ? step : -step;
        for (int i = 0; i < NS; i++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    p = (i * H + r) * W + c;
                    x = bx + i * XP + c;
                    y = wrap_y(by + i * YP + dy + r);
                    if (p < limit && x < SW) begin
                        e = '{0, t + p, x, y, col};
                        exp_q.push_back(e);
                    end
                end
    endtask

    task automatic start_go(input int bx, input int by, input int col, input int d,
                            output int t0);
        @(posedge clock);
        #1;
        base_x = 8'(bx);
        base_y = 7'(by);
        colour = 3'(col);
        dir    = (d != 0);
        go     = 1'b1;
        t0     = cyc + 2;
        @(posedge clock);
        #1;
        go = 1'b0;
    endtask

    // One animation run of nsteps steps, stopped during the last HOLD.
    task automatic run_anim(input int bx, input int by, input int col, input int d,
                            input int nsteps);
        int t0, t, tl, hold_at;
        ev_t e;
        start_go(bx, by, col, d, t0);
        for (int j = 0; j < nsteps; j++) begin
            t = t0 + j * PERIOD;
            push_scan(t, bx, by, col, j, d, SCAN);
            push_scan(t + SCAN + HOLD_CYC, bx, by, BG, j, d, SCAN);
            if (j < nsteps - 1) begin
                e = '{1, t + PERIOD - 1, 0, 0, 0};
                exp_q.push_back(e);
            end
        end
        tl = t0 + (nsteps - 1) * PERIOD;
        hold_at = tl + SCAN + int'($urandom_range(0, HOLD_CYC - 1));
        wait_cyc(hold_at);
        stop = 1'b1;
        @(posedge clock);
        #1;
        stop = 1'b0;
        wait_cyc(tl + PERIOD - 2);
        @(negedge clock);
        check("busy_last_erase", int'(busy), 1);
        wait_cyc(tl + PERIOD - 1);
        @(negedge clock);
        check("busy_after_stop", int'(busy), 0);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        $display("run bx=%0d by=%0d col=%0d dir=%0d steps=%0d done at cyc=%0d checks=%0d errors=%0d",
                 bx, by, col, d, nsteps, cyc, checks, errors);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int bx, by, col, d, n;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_out_x", int'(out_x), 0);
        check("rst_out_y", int'(out_y), 0);
        check("rst_out_colour", int'(out_colour), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_step_done", int'(step_done), 0);
        reset_n = 1'b1;

        // Basic draw, hold, erase, move, second draw
        run_anim(10, 20, 4, 0, 2);
        // Vertical wrap in both directions
        run_anim(10, 0, 2, 0, 2);
        run_anim(30, 119, 1, 1, 2);
        // Right-edge clipping
        run_anim(150, 40, 5, 1, 1);

        // go and stop together in IDLE: must stay idle
        @(posedge clock);
        #1;
        go   = 1'b1;
        stop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("idle_go_stop_busy", int'(busy), 0);
        end
        #1;
        go   = 1'b0;
        stop = 1'b0;
        $display("go+stop in IDLE held for 4 cycles at cyc=%0d", cyc);

        // Asynchronous reset in the middle of DRAW
        start_go(40, 50, 3, 1, t0);
        push_scan(t0, 40, 50, 3, 0, 1, 5);
        wait_cyc(t0 + 5);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_plot", int'(plot), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_out_x", int'(out_x), 0);
        check("arst_out_y", int'(out_y), 0);
        check("arst_pixels_before", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        $display("async reset mid-draw at cyc=%0d", cyc);
        run_anim(40, 50, 3, 1, 1);

        // Randomised runs
        for (int k = 0; k < 6; k++) begin
            bx  = int'($urandom_range(0, 159));
            by  = int'($urandom_range(0, 127));
            col = int'($urandom_range(0, 7));
            d   = int'($urandom_range(0, 1));
            n   = int'($urandom_range(1, 3));
            run_anim(bx, by, col, d, n);
        end

        repeat (3) @(negedge clock);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
